glb_stream_reader: RTL and testbench

Read-side initiator for the global buffer (GLB). On a start command it walks a byte range of the GLB through its 1-cycle-latency read port (`re`/`r_addr`/`dout`) and presents the returned words as a valid/ready stream toward the PE array. A small internal FIFO absorbs the GLB's fixed, non-stallable read latency so that downstream backpressure never loses data. The block issues partial-width reads for the tail of the range.

---
 rtl/glb_stream_reader.sv | 178 +++++++++++++++++
 tb/tb_glb_stream_reader.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_stream_reader.sv
// GLB read initiator: walks a byte range through the 1-cycle GLB read port and streams words out.
// Latency: start -> first read next cycle -> m_valid two cycles later; one beat/cycle when m_ready=1.
// Backpressure: credit (inflight + FIFO occupancy) stalls reads so returning data always has a slot.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld && (count != CW'(DEPTH));
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module glb_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    byte_len,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              glb_re,
  output logic [ADDR_WIDTH-1:0]   glb_r_addr,
  input  logic [DATA_WIDTH*4-1:0] glb_dout,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH*4-1:0] m_data,
  output logic [3:0]              m_keep,
  output logic                    m_last
);

  localparam int DW    = DATA_WIDTH * 4;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FW    = DW + 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr, last_addr;
  logic [LEN_WIDTH-1:0]  remaining, step;
  logic [3:0]            re_mask, tag_keep;
  logic                  inflight, tag_last;
  logic                  issue, issue_last, credit_ok, pop;
  logic [CNT_W-1:0]      occupancy;
  logic                  fifo_rd_vld;
  logic [FW-1:0]         fifo_rd_dat;

  always_comb begin
    re_mask = 4'b1111;
    step    = LEN_WIDTH'(4);
    if (remaining < LEN_WIDTH'(4)) begin
      step = remaining;
      case (remaining[1:0])
        2'd1:    re_mask = 4'b0001;
        2'd2:    re_mask = 4'b0011;
        2'd3:    re_mask = 4'b0111;
        default: re_mask = 4'b0000;
      endcase
    end
  end

  // Occupancy is sampled before this cycle's pop, so a same-cycle pop frees nothing yet.
  assign credit_ok  = ({1'b0, occupancy} + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue      = (state == RUN) && credit_ok;
  assign issue_last = (remaining <= LEN_WIDTH'(4));
  assign glb_re     = issue ? re_mask : 4'b0000;
  assign glb_r_addr = issue ? addr : last_addr;
  assign busy       = (state != IDLE);
  assign pop        = fifo_rd_vld && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      last_addr <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      tag_keep  <= 4'b0000;
      tag_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        tag_keep  <= re_mask;
        tag_last  <= issue_last;
        last_addr <= addr;
        addr      <= addr + ADDR_WIDTH'(4);
        remaining <= remaining - step;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (byte_len != '0) begin
              state     <= RUN;
              addr      <= base_addr;
              remaining <= byte_len;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && issue_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_ret_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (inflight),
    .wr_dat ({glb_dout, tag_keep, tag_last}),
    .rd_vld (fifo_rd_vld),
    .rd_rdy (m_ready),
    .rd_dat (fifo_rd_dat),
    .count  (occupancy)
  );

  assign m_valid = fifo_rd_vld;
  assign {m_data, m_keep, m_last} = fifo_rd_dat;

endmodule

// File: tb/tb_glb_stream_reader.sv
// Bench for glb_stream_reader: GLB memory responder, stream monitor and a range-walk reference model.
module tb_glb_stream_reader;

  localparam int AW = 32;
  localparam int LW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] byte_len = '0;
  logic          busy, done;
  logic [3:0]    glb_re;
  logic [AW-1:0] glb_r_addr;
  logic [DW-1:0] glb_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [3:0]    m_keep;
  logic          m_last;

  glb_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .byte_len(byte_len),
    .busy(busy), .done(done), .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_dout(glb_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] iss_addr[$];
  logic [3:0]    iss_re[$];
  int            iss_cyc[$];
  logic [DW-1:0] bt_dat[$];
  logic [3:0]    bt_keep[$];
  logic          bt_last[$];
  int            bt_cyc[$];
  int            done_cyc[$];
  bit            any_valid;

  logic [AW-1:0] exp_addr[$];
  logic [3:0]    exp_re[$];
  logic [DW-1:0] exp_dat[$];
  logic          exp_last[$];

  logic [3:0]    pend_re = '0;
  logic [AW-1:0] pend_addr = '0;

  // GLB contents: each byte is a fixed hash of its address.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    logic [AW-1:0] h;
    h = a * 32'h9E3779B1;
    return h[31:24] ^ a[7:0];
  endfunction

  function automatic logic [DW-1:0] glb_word(input logic [AW-1:0] a, input logic [3:0] re);
    logic [DW-1:0] w;
    w = '0;
    for (int b = 0; b < 4; b++)
      if (re[b]) w[8*b +: 8] = mem_byte(a + AW'(b));
    return w;
  endfunction

  always @(negedge clk) begin
    pend_re   = glb_re;
    pend_addr = glb_r_addr;
    if (glb_re != 4'b0000) begin
      iss_addr.push_back(glb_r_addr);
      iss_re.push_back(glb_re);
      iss_cyc.push_back(cyc);
    end
    if (m_valid) any_valid = 1'b1;
    if (m_valid && m_ready) begin
      bt_dat.push_back(m_data);
      bt_keep.push_back(m_keep);
      bt_last.push_back(m_last);
      bt_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  // 1-cycle read latency; garbage on the bus when no read was issued.
  always @(posedge clk) begin
    #1;
    glb_dout = (pend_re != 4'b0000) ? glb_word(pend_addr, pend_re) : DW'($urandom);
  end

  task automatic clear_logs();
    iss_addr.delete(); iss_re.delete(); iss_cyc.delete();
    bt_dat.delete(); bt_keep.delete(); bt_last.delete(); bt_cyc.delete();
    done_cyc.delete();
    any_valid = 1'b0;
  endtask

  task automatic model_cmd(input logic [AW-1:0] base, input int len);
    int n;
    logic [AW-1:0] a;
    logic [3:0] re;
    exp_addr.delete(); exp_re.delete(); exp_dat.delete(); exp_last.delete();
    for (int off = 0; off < len; off += 4) begin
      n  = (len - off >= 4) ? 4 : len - off;
      a  = base + AW'(off);
      re = 4'((1 << n) - 1);
      exp_addr.push_back(a);
      exp_re.push_back(re);
      exp_dat.push_back(glb_word(a, re));
      exp_last.push_back(off + 4 >= len);
    end
  endtask

  task automatic issue_start(input logic [AW-1:0] b, input int len, output int s_cyc);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; byte_len = LW'(len); s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; byte_len = LW'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit rand_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      if (done_cyc.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, m_valid, m_last} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got busy/done/valid/last=%b want 0000", {busy, done, m_valid, m_last});
    end
    checks++;
    if (glb_re !== 4'b0000 || glb_r_addr !== '0) begin
      failures++;
      $display("FAIL reset_rd got re=%b addr=%h want 0000/0", glb_re, glb_r_addr);
    end
    checks++;
    if (m_data !== '0 || m_keep !== 4'b0000) begin
      failures++;
      $display("FAIL reset_stream got data=%h keep=%b want 0/0000", m_data, m_keep);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || glb_re !== 4'b0000) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b re=%b want 0/0000", busy, glb_re);
    end
  endtask

  task automatic test_len16();
    int s; bit ok;
    m_ready = 1'b1;
    clear_logs();
    model_cmd(32'h100, 16);
    issue_start(32'h100, 16, s);
    wait_done(40, 1'b0, ok);
    repeat (3) @(posedge clk);
    checks++;
    if (!ok) begin failures++; $display("FAIL len16_timeout done not seen in 40 cycles"); end
    checks++;
    if (iss_addr.size() != exp_addr.size() || bt_dat.size() != exp_dat.size()) begin
      failures++;
      $display("FAIL len16_count got issues=%0d beats=%0d want %0d", iss_addr.size(), bt_dat.size(), exp_addr.size());
    end
    foreach (exp_addr[i]) begin
      checks++;
      if (iss_addr[i] !== exp_addr[i] || iss_re[i] !== exp_re[i]) begin
        failures++;
        $display("FAIL len16_issue[%0d] got %h/%b want %h/%b", i, iss_addr[i], iss_re[i], exp_addr[i], exp_re[i]);
      end
      checks++;
      if (bt_dat[i] !== exp_dat[i] || bt_keep[i] !== exp_re[i] || bt_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL len16_beat[%0d] got %h/%b/%b want %h/%b/%b", i, bt_dat[i], bt_keep[i], bt_last[i], exp_dat[i], exp_re[i], exp_last[i]);
      end
    end
    checks++;
    if (iss_cyc[0] != s + 1 || bt_cyc[0] != s + 3) begin
      failures++;
      $display("FAIL len16_latency got issue@+%0d valid@+%0d want +1/+3", iss_cyc[0] - s, bt_cyc[0] - s);
    end
    checks++;
    if (bt_cyc[3] - bt_cyc[0] != 3) begin
      failures++;
      $display("FAIL len16_throughput got span=%0d want 3", bt_cyc[3] - bt_cyc[0]);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - iss_cyc[0] != 6) begin
      failures++;
      $display("FAIL len16_done got pulses=%0d offset=%0d want 1/6", done_cyc.size(), done_cyc[0] - iss_cyc[0]);
    end
  endtask

  task automatic test_len7();
    int s; bit ok;
    m_ready = 1'b1;
    clear_logs();
    model_cmd(32'h20, 7);
    issue_start(32'h20, 7, s);
    wait_done(40, 1'b0, ok);
    repeat (3) @(posedge clk);
    checks++;
    if (!ok || iss_addr.size() != 2 || bt_dat.size() != 2) begin
      failures++;
      $display("FAIL len7_count got done=%b issues=%0d beats=%0d want 1/2/2", ok, iss_addr.size(), bt_dat.size());
    end
    foreach (exp_addr[i]) begin
      checks++;
      if (iss_addr[i] !== exp_addr[i] || iss_re[i] !== exp_re[i] || bt_dat[i] !== exp_dat[i] ||
          bt_keep[i] !== exp_re[i] || bt_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL len7_xfer[%0d] got %h/%b -> %h/%b/%b want %h/%b -> %h/%b/%b", i, iss_addr[i], iss_re[i],
                 bt_dat[i], bt_keep[i], bt_last[i], exp_addr[i], exp_re[i], exp_dat[i], exp_re[i], exp_last[i]);
      end
    end
    checks++;
    if (bt_dat[1][31:24] !== 8'h00 || bt_keep[1] !== 4'b0111) begin
      failures++;
      $display("FAIL len7_tail got top=%h keep=%b want 00/0111", bt_dat[1][31:24], bt_keep[1]);
    end
  endtask

  task automatic test_len0();
    int s;
    m_ready = 1'b1;
    clear_logs();
    issue_start(32'h40, 0, s);
    repeat (8) @(posedge clk);
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != s + 1) begin
      failures++;
      $display("FAIL len0_done got pulses=%0d at+%0d want 1/+1", done_cyc.size(), done_cyc[0] - s);
    end
    checks++;
    if (iss_addr.size() != 0 || any_valid) begin
      failures++;
      $display("FAIL len0_quiet got issues=%0d valid_seen=%b want 0/0", iss_addr.size(), any_valid);
    end
  endtask

  task automatic test_backpressure();
    int s, p; bit ok;
    logic [DW+4:0] snap;
    logic [AW-1:0] b;
    b = $urandom;
    m_ready = 1'b0;
    clear_logs();
    model_cmd(b, 32);
    issue_start(b, 32, s);
    repeat (6) @(posedge clk);
    @(negedge clk);
    snap = {m_data, m_keep, m_last};
    repeat (3) @(negedge clk);
    checks++;
    if (iss_addr.size() != 4 || glb_re !== 4'b0000) begin
      failures++;
      $display("FAIL bp_stall got issues=%0d re=%b want 4/0000", iss_addr.size(), glb_re);
    end
    checks++;
    if (m_valid !== 1'b1 || {m_data, m_keep, m_last} !== snap) begin
      failures++;
      $display("FAIL bp_stable got valid=%b beat=%h want 1/%h", m_valid, {m_data, m_keep, m_last}, snap);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    p = cyc;
    wait_done(60, 1'b0, ok);
    repeat (3) @(posedge clk);
    checks++;
    if (!ok || iss_addr.size() != 8 || bt_dat.size() != 8) begin
      failures++;
      $display("FAIL bp_count got done=%b issues=%0d beats=%0d want 1/8/8", ok, iss_addr.size(), bt_dat.size());
    end
    checks++;
    if (iss_cyc[4] != p + 1) begin
      failures++;
      $display("FAIL bp_resume got 5th issue at pop+%0d want pop+1", iss_cyc[4] - p);
    end
    foreach (exp_addr[i]) begin
      checks++;
      if (iss_addr[i] !== exp_addr[i] || bt_dat[i] !== exp_dat[i] || bt_keep[i] !== exp_re[i] || bt_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL bp_xfer[%0d] got %h -> %h/%b/%b want %h -> %h/%b/%b", i, iss_addr[i], bt_dat[i], bt_keep[i],
                 bt_last[i], exp_addr[i], exp_dat[i], exp_re[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int s; bit ok;
    logic [AW-1:0] b;
    b = 32'h1000 + AW'($urandom_range(0, 255));
    clear_logs();
    model_cmd(b, 20);
    issue_start(b, 20, s);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; base_addr = 32'hDEAD0000; byte_len = 16'd8;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200, 1'b1, ok);
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    checks++;
    if (!ok || done_cyc.size() != 1 || iss_addr.size() != exp_addr.size() || bt_dat.size() != exp_dat.size()) begin
      failures++;
      $display("FAIL restart_count got done=%0d issues=%0d beats=%0d want 1/%0d/%0d", done_cyc.size(),
               iss_addr.size(), bt_dat.size(), exp_addr.size(), exp_dat.size());
    end
    foreach (exp_addr[i]) begin
      checks++;
      if (iss_addr[i] !== exp_addr[i] || bt_dat[i] !== exp_dat[i] || bt_keep[i] !== exp_re[i] || bt_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL restart_xfer[%0d] got %h -> %h/%b/%b want %h -> %h/%b/%b", i, iss_addr[i], bt_dat[i],
                 bt_keep[i], bt_last[i], exp_addr[i], exp_dat[i], exp_re[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s; bit ok;
    m_ready = 1'b1;
    clear_logs();
    issue_start(32'h2000, 64, s);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, glb_re, glb_r_addr, m_valid, m_data, m_keep, m_last} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got busy=%b done=%b re=%b addr=%h valid=%b data=%h keep=%b last=%b want all 0",
               busy, done, glb_re, glb_r_addr, m_valid, m_data, m_keep, m_last);
    end
    clear_logs();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    checks++;
    if (iss_addr.size() != 0 || done_cyc.size() != 0 || any_valid) begin
      failures++;
      $display("FAIL midreset_abort got issues=%0d done=%0d valid_seen=%b want 0/0/0", iss_addr.size(), done_cyc.size(), any_valid);
    end
    clear_logs();
    model_cmd(32'h3000, 4);
    issue_start(32'h3000, 4, s);
    wait_done(30, 1'b0, ok);
    repeat (3) @(posedge clk);
    checks++;
    if (!ok || bt_dat.size() != 1 || bt_dat[0] !== exp_dat[0] || bt_keep[0] !== 4'b1111 || bt_last[0] !== 1'b1 ||
        iss_addr[0] !== 32'h3000) begin
      failures++;
      $display("FAIL midreset_after got done=%b beats=%0d beat=%h/%b/%b want 1/1/%h/1111/1", ok, bt_dat.size(),
               bt_dat[0], bt_keep[0], bt_last[0], exp_dat[0]);
    end
  endtask

  task automatic test_random();
    int s, len; bit ok, rr;
    logic [AW-1:0] b;
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 45);
      b   = $urandom;
      rr  = k[0];
      m_ready = 1'b1;
      clear_logs();
      model_cmd(b, len);
      issue_start(b, len, s);
      wait_done(400, rr, ok);
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      checks++;
      if (!ok || done_cyc.size() != 1 || iss_addr.size() != exp_addr.size() || bt_dat.size() != exp_dat.size()) begin
        failures++;
        $display("FAIL rand%0d_count len=%0d got done=%0d issues=%0d beats=%0d want 1/%0d/%0d", k, len,
                 done_cyc.size(), iss_addr.size(), bt_dat.size(), exp_addr.size(), exp_dat.size());
      end
      foreach (exp_addr[i]) begin
        checks++;
        if (iss_addr[i] !== exp_addr[i] || iss_re[i] !== exp_re[i] || bt_dat[i] !== exp_dat[i] ||
            bt_keep[i] !== exp_re[i] || bt_last[i] !== exp_last[i]) begin
          failures++;
          $display("FAIL rand%0d_xfer[%0d] got %h/%b -> %h/%b/%b want %h/%b -> %h/%b/%b", k, i, iss_addr[i], iss_re[i],
                   bt_dat[i], bt_keep[i], bt_last[i], exp_addr[i], exp_re[i], exp_dat[i], exp_re[i], exp_last[i]);
        end
      end
      if (!rr) begin
        checks++;
        if (done_cyc[0] - iss_cyc[0] != (len + 3) / 4 + 2) begin
          failures++;
          $display("FAIL rand%0d_done_time len=%0d got %0d want %0d", k, len, done_cyc[0] - iss_cyc[0], (len + 3) / 4 + 2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_len16();
    test_len7();
    test_len0();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
